// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a slow combinational ALU; ALU_ARB_PERF_EN adds per-requester response counters.
// Latency: response valid SETTLE_CYCLES edges after accept; one op per SETTLE_CYCLES+2 cycles at best.
// Backpressure: requesters see ready only in IDLE; response held stable until resp_ready.
module alu_arbiter #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_cmd,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_cmd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_result,
    output logic        resp_carryout,
    output logic        resp_zero,
    output logic        resp_overflow,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_cmd,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout,
    input  logic        alu_zero,
    input  logic        alu_overflow
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0] perf_cnt0,
    output logic [15:0] perf_cnt1
`endif
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("alu_arbiter: SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   op_a_q, op_a_d;
    logic [31:0]   op_b_q, op_b_d;
    logic [2:0]    op_cmd_q, op_cmd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          resp_vld_q, resp_vld_d;
    logic          resp_id_q, resp_id_d;
    logic [31:0]   resp_res_q, resp_res_d;
    logic          resp_co_q, resp_co_d;
    logic          resp_z_q, resp_z_d;
    logic          resp_ov_q, resp_ov_d;

    logic grant0, grant1, acc0, acc1;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last_q);
        grant1 = req1_valid && (!req0_valid || !last_q);
        acc0   = (state_q == IDLE) && grant0;
        acc1   = (state_q == IDLE) && grant1;
    end

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cmd_d   = op_cmd_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        resp_vld_d = resp_vld_q;
        resp_id_d  = resp_id_q;
        resp_res_d = resp_res_q;
        resp_co_d  = resp_co_q;
        resp_z_d   = resp_z_q;
        resp_ov_d  = resp_ov_q;
        case (state_q)
            IDLE: begin
                if (acc0 || acc1) begin
                    op_a_d    = acc1 ? req1_a   : req0_a;
                    op_b_d    = acc1 ? req1_b   : req0_b;
                    op_cmd_d  = acc1 ? req1_cmd : req0_cmd;
                    resp_id_d = acc1;
                    last_d    = acc1;
                    cnt_d     = '0;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    resp_res_d = alu_result;
                    resp_co_d  = alu_carryout;
                    resp_z_d   = alu_zero;
                    resp_ov_d  = alu_overflow;
                    resp_vld_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_vld_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cmd_q   <= '0;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            resp_vld_q <= 1'b0;
            resp_id_q  <= 1'b0;
            resp_res_q <= '0;
            resp_co_q  <= 1'b0;
            resp_z_q   <= 1'b0;
            resp_ov_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cmd_q   <= op_cmd_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            resp_vld_q <= resp_vld_d;
            resp_id_q  <= resp_id_d;
            resp_res_q <= resp_res_d;
            resp_co_q  <= resp_co_d;
            resp_z_q   <= resp_z_d;
            resp_ov_q  <= resp_ov_d;
        end
    end

    assign req0_ready    = acc0;
    assign req1_ready    = acc1;
    assign alu_a         = op_a_q;
    assign alu_b         = op_b_q;
    assign alu_cmd       = op_cmd_q;
    assign resp_valid    = resp_vld_q;
    assign resp_id       = resp_id_q;
    assign resp_result   = resp_res_q;
    assign resp_carryout = resp_co_q;
    assign resp_zero     = resp_z_q;
    assign resp_overflow = resp_ov_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] perf0_q, perf1_q;
    logic        resp_hs;

    assign resp_hs = resp_vld_q && resp_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else begin
            if (resp_hs && !resp_id_q && perf0_q != 16'hFFFF) perf0_q <= perf0_q + 16'd1;
            if (resp_hs &&  resp_id_q && perf1_q != 16'hFFFF) perf1_q <= perf1_q + 16'd1;
        end
    end

    assign perf_cnt0 = perf0_q;
    assign perf_cnt1 = perf1_q;
`endif

endmodule
